// File: rtl/load_store_queue.sv
// In-order load/store queue: a circular buffer of memory ops that wake up on the CDB,
// execute strictly from the head, and hold stores until the ROB commits them.
module load_store_queue #(
  parameter int DEPTH_LOG = 4,
  parameter int ENTRY_W   = 5
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               issue_valid,
  input  logic               issue_is_store,
  input  logic [2:0]         issue_op,
  input  logic [31:0]        issue_imm,
  input  logic [31:0]        issue_Vj,
  input  logic [31:0]        issue_Vk,
  input  logic [ENTRY_W-1:0] issue_Qj,
  input  logic [ENTRY_W-1:0] issue_Qk,
  input  logic [ENTRY_W-1:0] issue_entry,
  output logic               full_out,
  input  logic               roll_back,
  input  logic               cdb_valid,
  input  logic [ENTRY_W-1:0] cdb_entry,
  input  logic [31:0]        cdb_value,
  input  logic               commit_valid,
  input  logic [ENTRY_W-1:0] commit_entry,
  output logic               store_rdy_valid,
  output logic [ENTRY_W-1:0] store_rdy_entry,
  output logic               load_bc_valid,
  output logic [ENTRY_W-1:0] load_bc_entry,
  output logic [31:0]        load_bc_value,
  output logic               mem_req_valid,
  output logic               mem_req_we,
  output logic [31:0]        mem_req_addr,
  output logic [31:0]        mem_req_data,
  output logic [2:0]         mem_req_op,
  input  logic               mem_done,
  input  logic [31:0]        mem_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  typedef logic [DEPTH_LOG-1:0] ptr_t;
  typedef logic [DEPTH_LOG:0]   cnt_t;
  typedef logic [ENTRY_W-1:0]   tag_t;

  typedef enum logic [2:0] {
    ST_EMPTY     = 3'd0,
    ST_WAIT      = 3'd1,
    ST_READY     = 3'd2,
    ST_STRDY     = 3'd3,
    ST_COMMITTED = 3'd4,
    ST_MEM       = 3'd5
  } st_e;

  typedef struct packed {
    st_e         st;
    logic        is_store;
    logic [2:0]  op;
    logic [31:0] imm;
    logic [31:0] vj;
    logic [31:0] vk;
    tag_t        qj;
    tag_t        qk;
    tag_t        tag;
  } entry_t;

  entry_t      ent_q [DEPTH];
  entry_t      ent_d [DEPTH];
  ptr_t        head_q, head_d, rear_q, rear_d, exec_idx;
  cnt_t        count_q, count_d, cmt_q, cmt_d;
  logic        mem_valid_q, mem_valid_d, mem_we_q, mem_we_d, abort_q, abort_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
  logic [2:0]  mem_op_q, mem_op_d;
  logic        srdy_q, srdy_d, lbc_q, lbc_d;
  tag_t        srdy_entry_q, srdy_entry_d, lbc_entry_q, lbc_entry_d;
  logic [31:0] lbc_value_q, lbc_value_d;
  logic        issue_ok, mem_fire, cnt_inc, cnt_dec, cmt_inc, cmt_dec;
  entry_t      head_ent, exec_ent;

  function automatic logic tag_hit(input tag_t t, input logic v, input tag_t bus);
    return v && (t != '0) && (t == bus);
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [31:0] d);
    case (op)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'h0, d[7:0]};
      3'b101:  return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Stores become store-ready at the first uncommitted slot, so several can be committed ahead of memory.
  assign exec_idx = head_q + cmt_q[DEPTH_LOG-1:0];
  assign head_ent = ent_q[head_q];
  assign exec_ent = ent_q[exec_idx];
  assign full_out = (count_q == cnt_t'(DEPTH));
  assign issue_ok = issue_valid && !full_out && !roll_back;
  assign mem_fire = mem_valid_q && mem_done;

  always_comb begin
    ent_d        = ent_q;
    head_d       = head_q;
    rear_d       = rear_q;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_op_d     = mem_op_q;
    abort_d      = abort_q;
    srdy_d       = 1'b0;
    srdy_entry_d = srdy_entry_q;
    lbc_d        = 1'b0;
    lbc_entry_d  = lbc_entry_q;
    lbc_value_d  = lbc_value_q;
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;
    cmt_inc      = 1'b0;
    cmt_dec      = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      if (!roll_back && ent_q[i].st == ST_WAIT) begin
        if (ent_q[i].qj == '0 && ent_q[i].qk == '0) ent_d[i].st = ST_READY;
        if (tag_hit(ent_q[i].qj, cdb_valid, cdb_entry)) begin
          ent_d[i].vj = cdb_value;
          ent_d[i].qj = '0;
        end else if (tag_hit(ent_q[i].qj, lbc_q, lbc_entry_q)) begin
          ent_d[i].vj = lbc_value_q;
          ent_d[i].qj = '0;
        end
        if (tag_hit(ent_q[i].qk, cdb_valid, cdb_entry)) begin
          ent_d[i].vk = cdb_value;
          ent_d[i].qk = '0;
        end else if (tag_hit(ent_q[i].qk, lbc_q, lbc_entry_q)) begin
          ent_d[i].vk = lbc_value_q;
          ent_d[i].qk = '0;
        end
      end
    end

    if (issue_ok) begin
      ent_d[rear_q].st       = ST_WAIT;
      ent_d[rear_q].is_store = issue_is_store;
      ent_d[rear_q].op       = issue_op;
      ent_d[rear_q].imm      = issue_imm;
      ent_d[rear_q].tag      = issue_entry;
      ent_d[rear_q].vj       = issue_Vj;
      ent_d[rear_q].qj       = issue_Qj;
      ent_d[rear_q].vk       = issue_Vk;
      ent_d[rear_q].qk       = issue_Qk;
      if (tag_hit(issue_Qj, cdb_valid, cdb_entry)) begin
        ent_d[rear_q].vj = cdb_value;
        ent_d[rear_q].qj = '0;
      end else if (tag_hit(issue_Qj, lbc_q, lbc_entry_q)) begin
        ent_d[rear_q].vj = lbc_value_q;
        ent_d[rear_q].qj = '0;
      end
      if (tag_hit(issue_Qk, cdb_valid, cdb_entry)) begin
        ent_d[rear_q].vk = cdb_value;
        ent_d[rear_q].qk = '0;
      end else if (tag_hit(issue_Qk, lbc_q, lbc_entry_q)) begin
        ent_d[rear_q].vk = lbc_value_q;
        ent_d[rear_q].qk = '0;
      end
      rear_d  = rear_q + ptr_t'(1);
      cnt_inc = 1'b1;
    end

    if (!roll_back && exec_ent.st == ST_READY && exec_ent.is_store) begin
      ent_d[exec_idx].st = ST_STRDY;
      srdy_d             = 1'b1;
      srdy_entry_d       = exec_ent.tag;
    end
    if (!roll_back && commit_valid && exec_ent.st == ST_STRDY && exec_ent.tag == commit_entry) begin
      ent_d[exec_idx].st = ST_COMMITTED;
      cmt_inc            = 1'b1;
    end

    // Committed stores are architecturally done and still launch during a flush.
    if (!mem_valid_q && !abort_q &&
        (head_ent.st == ST_COMMITTED ||
         (!roll_back && head_ent.st == ST_READY && !head_ent.is_store))) begin
      ent_d[head_q].st = ST_MEM;
      mem_valid_d      = 1'b1;
      mem_we_d         = head_ent.is_store;
      mem_addr_d       = head_ent.vj + head_ent.imm;
      mem_data_d       = head_ent.vk;
      mem_op_d         = head_ent.op;
    end

    if (mem_fire) begin
      mem_valid_d      = 1'b0;
      ent_d[head_q].st = ST_EMPTY;
      head_d           = head_q + ptr_t'(1);
      cnt_dec          = 1'b1;
      if (head_ent.is_store) begin
        cmt_dec = 1'b1;
      end else if (!roll_back) begin
        lbc_d       = 1'b1;
        lbc_entry_d = head_ent.tag;
        lbc_value_d = load_ext(head_ent.op, mem_rdata);
      end
    end
    if (abort_q && mem_done) abort_d = 1'b0;

    count_d = count_q + cnt_t'(cnt_inc) - cnt_t'(cnt_dec);
    cmt_d   = cmt_q + cnt_t'(cmt_inc) - cnt_t'(cmt_dec);

    if (roll_back) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!(ent_d[i].st == ST_COMMITTED || (ent_d[i].st == ST_MEM && ent_d[i].is_store)))
          ent_d[i].st = ST_EMPTY;
      end
      // An aborted load still owes the memory one response; swallow it before issuing again.
      if (mem_valid_q && !head_ent.is_store && !mem_done) begin
        mem_valid_d = 1'b0;
        abort_d     = 1'b1;
      end
      rear_d  = head_d + cmt_d[DEPTH_LOG-1:0];
      count_d = cmt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q       <= '0;
      rear_q       <= '0;
      count_q      <= '0;
      cmt_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_op_q     <= '0;
      abort_q      <= 1'b0;
      srdy_q       <= 1'b0;
      srdy_entry_q <= '0;
      lbc_q        <= 1'b0;
      lbc_entry_q  <= '0;
      lbc_value_q  <= '0;
    end else if (rdy_in) begin
      ent_q        <= ent_d;
      head_q       <= head_d;
      rear_q       <= rear_d;
      count_q      <= count_d;
      cmt_q        <= cmt_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_op_q     <= mem_op_d;
      abort_q      <= abort_d;
      srdy_q       <= srdy_d;
      srdy_entry_q <= srdy_entry_d;
      lbc_q        <= lbc_d;
      lbc_entry_q  <= lbc_entry_d;
      lbc_value_q  <= lbc_value_d;
    end
  end

  assign store_rdy_valid = srdy_q && !roll_back;
  assign store_rdy_entry = srdy_entry_q;
  assign load_bc_valid   = lbc_q && !roll_back;
  assign load_bc_entry   = lbc_entry_q;
  assign load_bc_value   = lbc_value_q;
  assign mem_req_valid   = mem_valid_q;
  assign mem_req_we      = mem_we_q;
  assign mem_req_addr    = mem_addr_q;
  assign mem_req_data    = mem_data_q;
  assign mem_req_op      = mem_op_q;

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: loads, stores, wakeup, full/wrap, rollback and reset.
module tb_load_store_queue;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_valid, issue_is_store;
  logic [2:0]  issue_op;
  logic [31:0] issue_imm, issue_Vj, issue_Vk;
  logic [4:0]  issue_Qj, issue_Qk, issue_entry;
  logic        full_out, roll_back;
  logic        cdb_valid;
  logic [4:0]  cdb_entry;
  logic [31:0] cdb_value;
  logic        commit_valid;
  logic [4:0]  commit_entry;
  logic        store_rdy_valid;
  logic [4:0]  store_rdy_entry;
  logic        load_bc_valid;
  logic [4:0]  load_bc_entry;
  logic [31:0] load_bc_value;
  logic        mem_req_valid, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_data;
  logic [2:0]  mem_req_op;
  logic        mem_done;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_queue #(.DEPTH_LOG(4), .ENTRY_W(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_is_store(issue_is_store), .issue_op(issue_op),
    .issue_imm(issue_imm), .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
    .issue_Qj(issue_Qj), .issue_Qk(issue_Qk), .issue_entry(issue_entry),
    .full_out(full_out), .roll_back(roll_back),
    .cdb_valid(cdb_valid), .cdb_entry(cdb_entry), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_entry(commit_entry),
    .store_rdy_valid(store_rdy_valid), .store_rdy_entry(store_rdy_entry),
    .load_bc_valid(load_bc_valid), .load_bc_entry(load_bc_entry), .load_bc_value(load_bc_value),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_op(mem_req_op),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_issue(input logic st, input logic [2:0] op, input logic [31:0] imm,
                           input logic [31:0] vj, input logic [31:0] vk,
                           input logic [4:0] qj, input logic [4:0] qk, input logic [4:0] tag);
    issue_valid = 1'b1; issue_is_store = st; issue_op = op; issue_imm = imm;
    issue_Vj = vj; issue_Vk = vk; issue_Qj = qj; issue_Qk = qk; issue_entry = tag;
  endtask

  task automatic clr_issue();
    issue_valid = 1'b0; issue_is_store = 1'b0; issue_op = '0; issue_imm = '0;
    issue_Vj = '0; issue_Vk = '0; issue_Qj = '0; issue_Qk = '0; issue_entry = '0;
  endtask

  task automatic wait_req(input string name);
    for (int k = 0; k < 10; k++) begin
      if (mem_req_valid) break;
      step();
    end
    chk({name, "_req_seen"}, mem_req_valid, 1);
  endtask

  task automatic wait_srdy(input string name, input logic [4:0] tag);
    for (int k = 0; k < 10; k++) begin
      if (store_rdy_valid) break;
      step();
    end
    chk({name, "_srdy_seen"}, store_rdy_valid, 1);
    chk({name, "_srdy_entry"}, store_rdy_entry, tag);
  endtask

  task automatic do_load(input string name, input logic [2:0] op, input logic [31:0] rdata,
                         input logic [31:0] exp, input logic [4:0] tag);
    set_issue(1'b0, op, 32'h0, 32'h200, 32'h0, 5'd0, 5'd0, tag);
    step();
    clr_issue();
    wait_req(name);
    chk({name, "_op"}, mem_req_op, op);
    mem_done = 1'b1; mem_rdata = rdata;
    step();
    mem_done = 1'b0;
    chk({name, "_bc_valid"}, load_bc_valid, 1);
    chk({name, "_bc_value"}, load_bc_value, exp);
    chk({name, "_bc_entry"}, load_bc_entry, tag);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0;
    clr_issue();
    cdb_valid = 1'b0; cdb_entry = '0; cdb_value = '0;
    commit_valid = 1'b0; commit_entry = '0;
    mem_done = 1'b0; mem_rdata = '0;
    repeat (3) step();
    chk("rst_full", full_out, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_srdy", store_rdy_valid, 0);
    chk("rst_lbc", load_bc_valid, 0);
    chk("rst_count", dut.count_q, 0);
    rst_in = 1'b0;
    step();

    // LW: address appears two cycles after issue
    set_issue(1'b0, 3'b010, 32'h4, 32'h100, 32'h0, 5'd0, 5'd0, 5'd5);
    step();
    clr_issue();
    chk("lw_req_c1", mem_req_valid, 0);
    step();
    chk("lw_req_c2", mem_req_valid, 0);
    step();
    chk("lw_req_valid", mem_req_valid, 1);
    chk("lw_addr", mem_req_addr, 32'h104);
    chk("lw_we", mem_req_we, 0);
    chk("lw_op", mem_req_op, 3'b010);
    step();
    chk("lw_hold_valid", mem_req_valid, 1);
    chk("lw_hold_addr", mem_req_addr, 32'h104);
    mem_done = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_done = 1'b0;
    chk("lw_bc_valid", load_bc_valid, 1);
    chk("lw_bc_value", load_bc_value, 32'hDEADBEEF);
    chk("lw_bc_entry", load_bc_entry, 5);
    chk("lw_req_drop", mem_req_valid, 0);
    step();
    chk("lw_bc_pulse", load_bc_valid, 0);

    do_load("lb",  3'b000, 32'h0000_0080, 32'hFFFF_FF80, 5'd6);
    do_load("lbu", 3'b100, 32'h0000_0080, 32'h0000_0080, 5'd7);
    do_load("lh",  3'b001, 32'h1234_8001, 32'hFFFF_8001, 5'd9);
    do_load("lhu", 3'b101, 32'h1234_8001, 32'h0000_8001, 5'd10);
    step();

    // Store with CDB bypass on its issue cycle
    set_issue(1'b1, 3'b010, 32'h8, 32'h300, 32'h0, 5'd0, 5'd3, 5'd7);
    cdb_valid = 1'b1; cdb_entry = 5'd3; cdb_value = 32'h55;
    step();
    clr_issue(); cdb_valid = 1'b0;
    chk("st_srdy_c1", store_rdy_valid, 0);
    step();
    chk("st_srdy_c2", store_rdy_valid, 0);
    step();
    chk("st_srdy_valid", store_rdy_valid, 1);
    chk("st_srdy_entry", store_rdy_entry, 7);
    chk("st_no_req", mem_req_valid, 0);
    commit_valid = 1'b1; commit_entry = 5'd7;
    step();
    commit_valid = 1'b0;
    chk("st_srdy_pulse", store_rdy_valid, 0);
    chk("st_req_early", mem_req_valid, 0);
    step();
    chk("st_req_valid", mem_req_valid, 1);
    chk("st_we", mem_req_we, 1);
    chk("st_data", mem_req_data, 32'h55);
    chk("st_addr", mem_req_addr, 32'h308);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    chk("st_done", mem_req_valid, 0);
    chk("st_no_bc", load_bc_valid, 0);

    // Load waiting on a tag, woken by the CDB
    set_issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd4, 5'd0, 5'd8);
    step();
    clr_issue();
    step(); step();
    chk("wk_waiting", mem_req_valid, 0);
    cdb_valid = 1'b1; cdb_entry = 5'd4; cdb_value = 32'h400;
    step();
    cdb_valid = 1'b0;
    wait_req("wk");
    chk("wk_addr", mem_req_addr, 32'h410);
    mem_done = 1'b1; mem_rdata = 32'h0;
    step();
    mem_done = 1'b0;
    step();

    // Fill all 16 slots starting at index 7, wrapping through 15 -> 0
    for (int i = 0; i < 16; i++) begin
      set_issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, (i == 0) ? 5'd10 : 5'd9, 5'd0, 5'(11 + i));
      step();
      if (i == 14) chk("fill_not_full", full_out, 0);
    end
    clr_issue();
    chk("fill_full", full_out, 1);
    chk("fill_count", dut.count_q, 16);
    chk("fill_rear_wrap", dut.rear_q, 7);
    set_issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 5'd9, 5'd0, 5'd30);
    step();
    clr_issue();
    chk("ovf_full", full_out, 1);
    chk("ovf_count", dut.count_q, 16);
    cdb_valid = 1'b1; cdb_entry = 5'd10; cdb_value = 32'h500;
    step();
    cdb_valid = 1'b0;
    wait_req("fill");
    chk("fill_addr", mem_req_addr, 32'h500);
    mem_done = 1'b1; mem_rdata = 32'h1122_3344;
    step();
    mem_done = 1'b0;
    chk("free_full", full_out, 0);
    chk("free_bc_entry", load_bc_entry, 11);
    chk("free_head", dut.head_q, 8);
    set_issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 5'd9, 5'd0, 5'd27);
    step();
    clr_issue();
    chk("refill_full", full_out, 1);
    chk("refill_rear", dut.rear_q, 8);
    roll_back = 1'b1;
    step();
    roll_back = 1'b0;
    chk("rb_full", full_out, 0);
    chk("rb_count", dut.count_q, 0);
    chk("rb_rear", dut.rear_q, 8);

    // Rollback aborts an in-flight load; the late response is swallowed
    set_issue(1'b0, 3'b010, 32'h0, 32'h600, 32'h0, 5'd0, 5'd0, 5'd12);
    step();
    clr_issue();
    wait_req("ab");
    chk("ab_addr", mem_req_addr, 32'h600);
    roll_back = 1'b1;
    step();
    roll_back = 1'b0;
    chk("ab_req_drop", mem_req_valid, 0);
    chk("ab_bc", load_bc_valid, 0);
    step();
    mem_done = 1'b1; mem_rdata = 32'hCAFE;
    step();
    mem_done = 1'b0;
    chk("ab_late_bc", load_bc_valid, 0);
    step();
    chk("ab_late_bc2", load_bc_valid, 0);
    chk("ab_count", dut.count_q, 0);
    chk("ab_head", dut.head_q, 8);

    // Two committed stores and three loads, then rollback
    set_issue(1'b1, 3'b010, 32'h0, 32'h700, 32'h0, 5'd0, 5'd20, 5'd13);
    step();
    set_issue(1'b1, 3'b010, 32'h0, 32'h704, 32'h0, 5'd0, 5'd21, 5'd14);
    step();
    for (int i = 0; i < 3; i++) begin
      set_issue(1'b0, 3'b010, 32'h0, 32'h800, 32'h0, 5'd0, 5'd0, 5'(15 + i));
      step();
    end
    clr_issue();
    cdb_valid = 1'b1; cdb_entry = 5'd20; cdb_value = 32'hA1;
    step();
    cdb_entry = 5'd21; cdb_value = 32'hB2;
    step();
    cdb_valid = 1'b0;
    wait_srdy("sa", 5'd13);
    commit_valid = 1'b1; commit_entry = 5'd13;
    step();
    commit_valid = 1'b0;
    wait_srdy("sb", 5'd14);
    commit_valid = 1'b1; commit_entry = 5'd14;
    step();
    commit_valid = 1'b0;
    chk("pre_rb_count", dut.count_q, 5);
    roll_back = 1'b1;
    step();
    roll_back = 1'b0;
    chk("rb2_count", dut.count_q, 2);
    chk("rb2_head", dut.head_q, 8);
    chk("rb2_rear", dut.rear_q, 10);
    chk("rb2_req_valid", mem_req_valid, 1);
    chk("rb2_addr_a", mem_req_addr, 32'h700);
    chk("rb2_we_a", mem_req_we, 1);
    chk("rb2_data_a", mem_req_data, 32'hA1);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    chk("rb2_a_done", mem_req_valid, 0);
    wait_req("sb_mem");
    chk("rb2_addr_b", mem_req_addr, 32'h704);
    chk("rb2_data_b", mem_req_data, 32'hB2);
    chk("rb2_we_b", mem_req_we, 1);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    chk("rb2_final_count", dut.count_q, 0);
    chk("rb2_final_head", dut.head_q, 10);

    // rdy_in low freezes the queue
    rdy_in = 1'b0;
    set_issue(1'b0, 3'b010, 32'h0, 32'h900, 32'h0, 5'd0, 5'd0, 5'd18);
    step(); step();
    clr_issue();
    rdy_in = 1'b1;
    chk("hold_count", dut.count_q, 0);
    chk("hold_req", mem_req_valid, 0);

    // Reset in the middle of a load discards it
    set_issue(1'b0, 3'b010, 32'h0, 32'hA00, 32'h0, 5'd0, 5'd0, 5'd19);
    step();
    clr_issue();
    wait_req("rstm");
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk("rstm_req", mem_req_valid, 0);
    chk("rstm_count", dut.count_q, 0);
    chk("rstm_head", dut.head_q, 0);
    chk("rstm_full", full_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
